// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter between ALU and load results, with a register-pending
// scoreboard that stalls issue and tracks in-flight destination registers.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            i_clock,
  input  logic            i_rst,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  output logic            o_issue_ready,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_ready,
  input  logic            i_mem_valid,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_mem_ready,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_rdaddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic [NREG-1:0] o_busy_vec
);

  localparam int unsigned IDX_W = 5;

  logic              r_alu_last;
  logic              r_rf_wen;
  logic [IDX_W-1:0]  r_rf_rdaddr;
  logic [XLEN-1:0]   r_rf_wdata;
  logic [NREG-1:0]   r_busy;

  logic              w_alu_gnt;
  logic              w_mem_gnt;
  logic              w_gnt;
  logic [IDX_W-1:0]  w_wb_rd;
  logic [XLEN-1:0]   w_wb_data;
  logic              w_issue_ready;
  logic              w_issue_fire;
  logic [NREG-1:0]   w_busy_nxt;

  // Indices beyond NREG read as not pending.
  function automatic logic busy_at(input logic [NREG-1:0] vec,
                                   input logic [IDX_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx == IDX_W'(i)) hit = vec[i];
    end
    return hit;
  endfunction

  // Round-robin grant: r_alu_last means the ALU won the latest grant.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    if (!i_rst) begin
      if (i_alu_valid && i_mem_valid) begin
        w_mem_gnt = r_alu_last;
        w_alu_gnt = !r_alu_last;
      end else begin
        w_alu_gnt = i_alu_valid;
        w_mem_gnt = i_mem_valid;
      end
    end
  end

  assign w_gnt     = w_alu_gnt | w_mem_gnt;
  assign w_wb_rd   = w_alu_gnt ? i_alu_rd   : i_mem_rd;
  assign w_wb_data = w_alu_gnt ? i_alu_data : i_mem_data;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_alu_last <= 1'b1;
    end else if (w_gnt) begin
      r_alu_last <= w_alu_gnt;
    end
  end

  // Registered write port; x0 writes handshake but never assert the enable.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_rf_wen    <= 1'b0;
      r_rf_rdaddr <= '0;
      r_rf_wdata  <= '0;
    end else if (w_gnt) begin
      r_rf_wen    <= (w_wb_rd != '0);
      r_rf_rdaddr <= w_wb_rd;
      r_rf_wdata  <= w_wb_data;
    end else begin
      r_rf_wen    <= 1'b0;
    end
  end

  assign w_issue_ready = !i_rst &&
                         ((i_issue_rd == '0) || !busy_at(r_busy, i_issue_rd));
  assign w_issue_fire  = i_issue_valid && w_issue_ready;

  // Clear follows the committed write; a same-index issue overrides it.
  always_comb begin
    w_busy_nxt = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_busy_nxt[i] = r_busy[i];
      if (r_rf_wen && (r_rf_rdaddr == IDX_W'(i))) w_busy_nxt[i] = 1'b0;
      if (w_issue_fire && (i_issue_rd == IDX_W'(i))) w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_alu_ready   = w_alu_gnt;
  assign o_mem_ready   = w_mem_gnt;
  assign o_issue_ready = w_issue_ready;
  assign o_rs1_busy    = busy_at(r_busy, i_rs1_addr);
  assign o_rs2_busy    = busy_at(r_busy, i_rs2_addr);
  assign o_rf_wen      = r_rf_wen;
  assign o_rf_rdaddr   = r_rf_rdaddr;
  assign o_rf_wdata    = r_rf_wdata;
  assign o_busy_vec    = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level reference model of the scoreboard.
module tb_regfile_wb_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic            alu_valid, mem_valid;
  logic [4:0]      alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            rs1_busy, rs2_busy;
  logic            rf_wen;
  logic [4:0]      rf_rdaddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy_vec;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [NREG-1:0] m_busy;
  bit            m_alu_won_last;
  bit            m_wen;
  bit [4:0]      m_addr;
  bit [XLEN-1:0] m_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .i_clock(clk), .i_rst(rst),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_data(mem_data), .o_mem_ready(mem_ready),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_rf_wen(rf_wen), .o_rf_rdaddr(rf_rdaddr), .o_rf_wdata(rf_wdata), .o_busy_vec(busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input bit iv, input bit [4:0] ird,
                        input bit av, input bit [4:0] ard, input bit [XLEN-1:0] ad,
                        input bit mv, input bit [4:0] mrd, input bit [XLEN-1:0] md);
    rst = r; issue_valid = iv; issue_rd = ird;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  // Check all outputs for the current cycle, then advance model and DUT one edge.
  task automatic cycle();
    bit a_g, m_g, i_r, fire;
    bit [4:0] wrd;
    bit [XLEN-1:0] wdat;
    #1;
    if (rst) begin
      a_g = 0; m_g = 0;
    end else if (alu_valid && mem_valid) begin
      m_g = m_alu_won_last; a_g = !m_alu_won_last;
    end else begin
      a_g = alu_valid; m_g = mem_valid;
    end
    i_r  = !rst && (issue_rd == 0 || !m_busy[issue_rd]);
    fire = issue_valid && i_r;
    check("alu_ready", 64'(alu_ready), 64'(a_g));
    check("mem_ready", 64'(mem_ready), 64'(m_g));
    check("issue_ready", 64'(issue_ready), 64'(i_r));
    check("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
    check("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
    check("rf_wen", 64'(rf_wen), 64'(m_wen));
    check("rf_rdaddr", 64'(rf_rdaddr), 64'(m_addr));
    check("rf_wdata", 64'(rf_wdata), 64'(m_data));
    check("busy_vec", 64'(busy_vec), 64'(m_busy));
    if (rst) begin
      m_busy = '0; m_wen = 0; m_addr = '0; m_data = '0; m_alu_won_last = 1;
    end else begin
      if (m_wen) m_busy[m_addr] = 1'b0;
      if (fire && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (a_g || m_g) begin
        wrd  = a_g ? alu_rd : mem_rd;
        wdat = a_g ? alu_data : mem_data;
        m_wen = (wrd != 0); m_addr = wrd; m_data = wdat;
        m_alu_won_last = a_g;
      end else begin
        m_wen = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = '0; m_wen = 0; m_addr = '0; m_data = '0; m_alu_won_last = 1;
    cycle();
    check("reset_busy_vec", 64'(busy_vec), 64'h0);
    check("reset_rf_wen", 64'(rf_wen), 64'h0);

    // Issue rd=5, then a second issue to rd=5 must stall
    rs1_addr = 5;
    set_in(0, 1, 5, 0, 0, 0, 0, 0, 0);
    cycle();
    check("issue5_busy_vec", 64'(busy_vec), 64'h20);
    check("issue5_rs1_busy", 64'(rs1_busy), 64'h1);
    #1 check("issue5_again_ready", 64'(issue_ready), 64'h0);
    cycle();

    // ALU write-back to x5
    set_in(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    #1 check("alu5_ready", 64'(alu_ready), 64'h1);
    cycle();
    check("alu5_wen", 64'(rf_wen), 64'h1);
    check("alu5_addr", 64'(rf_rdaddr), 64'h5);
    check("alu5_data", 64'(rf_wdata), 64'hDEADBEEF);
    check("alu5_busy_held", 64'(busy_vec[5]), 64'h1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("alu5_busy_clr", 64'(busy_vec[5]), 64'h0);

    // Round-robin from reset: mem, alu, mem, alu
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 0, 1, 5'(k + 1), 32'(k), 1, 5'(k + 9), 32'(k + 100));
      #1 check("rr_mem_ready", 64'(mem_ready), 64'((k % 2) == 0));
      check("rr_alu_ready", 64'(alu_ready), 64'((k % 2) == 1));
      cycle();
    end

    // mem write to x0: handshake, no enable
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 32'h1234);
    #1 check("x0_mem_ready", 64'(mem_ready), 64'h1);
    cycle();
    check("x0_rf_wen", 64'(rf_wen), 64'h0);

    // Write to non-busy x7 then issue x7 while that write commits: set wins
    set_in(0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    cycle();
    set_in(0, 1, 7, 0, 0, 0, 0, 0, 0);
    check("x7_wen", 64'(rf_wen), 64'h1);
    cycle();
    check("x7_set_wins", 64'(busy_vec[7]), 64'h1);

    // Reset right after a grant
    set_in(0, 0, 0, 1, 3, 32'h33, 0, 0, 0);
    cycle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("rst_mid_wen", 64'(rf_wen), 64'h0);
    check("rst_mid_busy", 64'(busy_vec), 64'h0);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 59) == 0),
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom(),
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom());
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have the parameter XLEN, default 32, setting the data width of every write-data path.
REQ-002 The block SHALL have the parameter NREG, default 32, setting the architectural register count; register indices are 5 bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 issue_valid  input  1  decode requests to mark issue_rd as pending.
REQ-007 issue_rd  input  5  destination register of the issuing instruction.
REQ-008 issue_ready  output  1  issue accepted this cycle.
REQ-009 alu_valid / alu_rd / alu_data  input  1/5/XLEN  ALU write-back request.
REQ-010 alu_ready  output  1  ALU request granted this cycle.
REQ-011 mem_valid / mem_rd / mem_data  input  1/5/XLEN  load write-back request.
REQ-012 mem_ready  output  1  load request granted this cycle.
REQ-013 rs1_addr, rs2_addr  input  5  source registers being read by decode.
REQ-014 rs1_busy, rs2_busy  output  1  the source register has a pending write.
REQ-015 rf_wen / rf_rdaddr / rf_wdata  output  1/5/XLEN  registered register-file write port.
REQ-016 busy_vec  output  NREG  scoreboard state, bit i = register i pending.

Function
REQ-017 A requester's write-back SHALL transfer on a cycle where its valid and ready are both high; ready SHALL be combinational from the valids and the arbitration pointer.
REQ-018 At most one of alu_ready and mem_ready SHALL be high in any cycle.
REQ-019 With exactly one requester valid, that requester SHALL be granted.
REQ-020 With both valid, the grant SHALL go to the requester not granted most recently, using a 1-bit pointer updated only on a grant.
REQ-021 A grant at rising edge E SHALL register rf_wen, rf_rdaddr and rf_wdata so they are visible in the cycle following E; latency is exactly one cycle.
REQ-022 With no grant, rf_wen SHALL be 0 in the next cycle; rf_rdaddr and rf_wdata SHALL hold their values.
REQ-023 A granted write to register 0 SHALL complete its handshake but SHALL register rf_wen=0.
REQ-024 issue_ready SHALL equal NOT busy_vec[issue_rd], except that issue_ready SHALL be 1 when issue_rd=0.
REQ-025 An issue handshake with issue_rd!=0 SHALL set busy_vec[issue_rd] at that edge.
REQ-026 busy_vec[i] SHALL clear at the edge ending a cycle in which rf_wen=1 and rf_rdaddr=i, so the cleared bit coincides with the register file holding the new value.
REQ-027 If a set and a clear target the same index at the same edge, the set SHALL win.
REQ-028 busy_vec[0] SHALL be constantly 0.
REQ-029 rsN_busy SHALL equal busy_vec[rsN_addr] combinationally; there is no bypass.
REQ-030 A write-back to a register whose busy bit is 0 SHALL still be performed; the bit stays 0.

Reset
REQ-031 While rst=1 at an edge, busy_vec, rf_wen, rf_rdaddr and rf_wdata SHALL become 0 and the pointer SHALL favour mem first.
REQ-032 While rst=1, alu_ready, mem_ready and issue_ready SHALL be 0, and no handshake SHALL occur.
REQ-033 A reset asserted mid-operation SHALL discard all pending state, with no write issued after reset.

Verification
REQ-034 Reset, then issue rd=5 -> busy_vec=0x20, rs1_busy=1 for rs1_addr=5, and issue_ready=0 for a second issue to rd=5.
REQ-035 ALU write rd=5, data 0xDEADBEEF -> alu_ready=1 that cycle; next cycle rf_wen=1, rf_rdaddr=5, rf_wdata=0xDEADBEEF; busy_vec[5] clears one edge later.
REQ-036 Both valid for 4 consecutive cycles after reset -> grants in order mem, alu, mem, alu.
REQ-037 mem write to rd=0 -> mem_ready=1, rf_wen stays 0, busy_vec unchanged.
REQ-038 rf_wen=1, rf_rdaddr=7 and issue rd=7 in the same cycle -> busy_vec[7]=1 after the edge.
REQ-039 Assert rst the cycle after a grant -> rf_wen=0 and busy_vec=0 on the next cycle.
